// File: rtl/boot_loader_if.sv
// Loader-side bundle: incoming byte stream, program-memory write port and CPU/status outputs.
// The loader connects through master; the environment (stream source, memory, CPU) uses slave.
interface boot_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  start, in_data, in_valid,
    output in_ready, pm_we, pm_addr, pm_wdata, cpu_reset, busy, done, error, word_count
  );

  modport slave (
    output start, in_data, in_valid,
    input  in_ready, pm_we, pm_addr, pm_wdata, cpu_reset, busy, done, error, word_count
  );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses length, data words and checksum, writes program memory
// and releases the CPU reset only after the checksum matches.
module boot_loader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int AUTO_START = 1
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CHK_HI, CHK_LO, RUN, ERROR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_W);

  state_t            state;
  state_t            state_nxt;
  logic              xfer;
  logic [15:0]       len;
  logic [7:0]        word_hi;
  logic [7:0]        chk_hi;
  logic [15:0]       sum;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] pm_addr_q;
  logic [DATA_W-1:0] pm_wdata_q;
  logic [16:0]       hdr_len;
  logic [16:0]       cnt_inc;

  assign xfer    = bus.in_valid & bus.in_ready;
  assign hdr_len = {1'b0, len[15:8], bus.in_data};
  assign cnt_inc = 17'(cnt) + 17'd1;

  always_ff @(posedge clk) begin
    if (!reset) state <= (AUTO_START != 0) ? HDR_HI : IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = HDR_HI;
      HDR_HI:  if (xfer) state_nxt = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (hdr_len > MAX_LEN)   state_nxt = ERROR;
          else if (hdr_len == '0)  state_nxt = CHK_HI;
          else                     state_nxt = DATA_HI;
        end
      end
      DATA_HI: if (xfer) state_nxt = DATA_LO;
      DATA_LO: if (xfer) state_nxt = WRITE;
      WRITE:   state_nxt = (cnt_inc == {1'b0, len}) ? CHK_HI : DATA_HI;
      CHK_HI:  if (xfer) state_nxt = CHK_LO;
      CHK_LO: begin
        if (xfer) state_nxt = ({chk_hi, bus.in_data} == sum) ? RUN : ERROR;
      end
      RUN:     if (bus.start) state_nxt = HDR_HI;
      ERROR:   if (bus.start) state_nxt = HDR_HI;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and handshake outputs are pure decodes of the current state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.pm_we     = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.error     = 1'b0;
    bus.cpu_reset = 1'b1;
    case (state)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      WRITE: begin
        bus.pm_we = 1'b1;
        bus.busy  = 1'b1;
      end
      RUN: begin
        bus.done      = 1'b1;
        bus.cpu_reset = 1'b0;
      end
      ERROR:   bus.error = 1'b1;
      default: ;
    endcase
  end

  // Write address/data are captured on the last byte of a word so they only move into WRITE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len        <= '0;
      word_hi    <= '0;
      chk_hi     <= '0;
      sum        <= '0;
      cnt        <= '0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERROR: if (bus.start) cnt <= '0;
        HDR_HI:  if (xfer) len[15:8] <= bus.in_data;
        HDR_LO: begin
          if (xfer) begin
            len[7:0] <= bus.in_data;
            cnt      <= '0;
            sum      <= '0;
          end
        end
        DATA_HI: if (xfer) word_hi <= bus.in_data;
        DATA_LO: begin
          if (xfer) begin
            pm_addr_q  <= cnt[ADDR_W-1:0];
            pm_wdata_q <= DATA_W'({word_hi, bus.in_data});
          end
        end
        WRITE: begin
          sum <= sum + 16'(pm_wdata_q);
          cnt <= cnt + (ADDR_W+1)'(1);
        end
        CHK_HI:  if (xfer) chk_hi <= bus.in_data;
        default: ;
      endcase
    end
  end

  assign bus.pm_addr    = pm_addr_q;
  assign bus.pm_wdata   = pm_wdata_q;
  assign bus.word_count = cnt;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed and random byte streams checked against a stream/memory model.
module tb_boot_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  boot_loader #(.ADDR_W(10), .DATA_W(16), .AUTO_START(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [15:0] mem [0:1023];
  logic [25:0] wr_q [$];

  // Program memory plus a log of every write strobe seen.
  always @(posedge clk) begin
    if (bus.pm_we === 1'b1) begin
      mem[bus.pm_addr] <= bus.pm_wdata;
      wr_q.push_back({bus.pm_addr, bus.pm_wdata});
      if (bus.in_ready !== 1'b0) viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference stream: length, words, modulo-2^16 sum of the words (+1 when corrupted).
  task automatic build(input logic [15:0] words[$], input bit bad, output logic [7:0] bytes[$]);
    int unsigned s;
    logic [15:0] n;
    logic [15:0] c;
    s = 0;
    n = 16'(words.size());
    bytes = {};
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    foreach (words[i]) begin
      s = s + words[i];
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
    end
    c = 16'(s % 65536) + (bad ? 16'd1 : 16'd0);
    bytes.push_back(c[15:8]);
    bytes.push_back(c[7:0]);
  endtask

  task automatic rand_words(input int n, input int lo, output logic [15:0] words[$]);
    words = {};
    for (int i = 0; i < n; i++) words.push_back(16'($urandom_range(16'hFFFF, lo)));
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int budget;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 1) : 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) send_byte(bytes[i], max_gap);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_busy",   32'(bus.busy),       32'd1);
    check("start_cpurst", 32'(bus.cpu_reset),  32'd1);
    check("start_wc",     32'(bus.word_count), 32'd0);
    check("start_done",   32'(bus.done),       32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] words[$], input bit ok);
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(words.size()));
    foreach (words[i])
      if (i < wr_q.size()) check({tag, "_wr"}, 32'(wr_q[i]), 32'({10'(i), words[i]}));
    check({tag, "_done"},  32'(bus.done),       32'(ok));
    check({tag, "_error"}, 32'(bus.error),      32'(!ok));
    check({tag, "_cpurst"},32'(bus.cpu_reset),  32'(!ok));
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_rdy"},   32'(bus.in_ready),   32'd0);
    check({tag, "_wc"},    32'(bus.word_count), 32'(words.size()));
  endtask

  task automatic do_load(input string tag, input logic [7:0] bytes[$], input logic [15:0] words[$],
                         input bit ok, input int max_gap);
    wr_q.delete();
    send_bytes(bytes, 0, bytes.size() - 1, max_gap);
    check_result(tag, words, ok);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpurst"}, 32'(bus.cpu_reset),  32'd1);
    check({tag, "_we"},     32'(bus.pm_we),      32'd0);
    check({tag, "_addr"},   32'(bus.pm_addr),    32'd0);
    check({tag, "_wdata"},  32'(bus.pm_wdata),   32'd0);
    check({tag, "_wc"},     32'(bus.word_count), 32'd0);
    check({tag, "_done"},   32'(bus.done),       32'd0);
    check({tag, "_error"},  32'(bus.error),      32'd0);
    check({tag, "_busy"},   32'(bus.busy),       32'd1);
    check({tag, "_rdy"},    32'(bus.in_ready),   32'd1);
  endtask

  logic [7:0]  s_ok [$];
  logic [7:0]  s_bad[$];
  logic [7:0]  s_tmp[$];
  logic [15:0] w2 [$];
  logic [15:0] wr [$];
  logic [15:0] none [$];

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    s_ok  = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    s_bad = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    w2    = {16'h1234, 16'hABCD};
    none  = {};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(bus.busy), 32'd1);

    do_load("basic", s_ok, w2, 1'b1, 0);
    check("basic_mem0", 32'(mem[0]), 32'h1234);
    check("basic_mem1", 32'(mem[1]), 32'hABCD);

    pulse_start();
    do_load("badchk", s_bad, w2, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("err_hold",    32'(bus.error),     32'd1);
    check("err_hold_cr", 32'(bus.cpu_reset), 32'd1);
    pulse_start();
    do_load("recover", s_ok, w2, 1'b1, 0);

    pulse_start();
    do_load("empty", {8'h00, 8'h00, 8'h00, 8'h00}, none, 1'b1, 0);

    pulse_start();
    wr_q.delete();
    send_bytes({8'h04, 8'h01}, 0, 1, 0);
    check("toolong_err",  32'(bus.error),    32'd1);
    check("toolong_rdy",  32'(bus.in_ready), 32'd0);
    check("toolong_busy", 32'(bus.busy),     32'd0);
    check("toolong_nwr",  32'(wr_q.size()),  32'd0);

    pulse_start();
    mem[0] = 16'h0; mem[1] = 16'h0;
    do_load("gaps", s_ok, w2, 1'b1, 3);
    check("gaps_mem0",  32'(mem[0]), 32'h1234);
    check("gaps_mem1",  32'(mem[1]), 32'hABCD);
    check("we_vs_rdy",  32'(viol),   32'd0);

    // start pulse in the middle of a load must be ignored
    pulse_start();
    wr_q.delete();
    send_bytes(s_ok, 0, 3, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ign_busy", 32'(bus.busy),       32'd1);
    check("ign_wc",   32'(bus.word_count), 32'd1);
    send_bytes(s_ok, 4, 7, 0);
    check_result("ign", w2, 1'b1);

    // reset while in DATA_LO of word 1
    pulse_start();
    wr = {16'h1111, 16'h2222, 16'h3333};
    build(wr, 1'b0, s_tmp);
    wr_q.delete();
    send_bytes(s_tmp, 0, 4, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    check("midrst_nwr",  32'(wr_q.size()), 32'd1);
    check("midrst_mem0", 32'(mem[0]),      32'h1111);
    reset = 1'b1;
    do_load("reload", s_tmp, wr, 1'b1, 0);

    for (int k = 0; k < 6; k++) begin
      bit bad;
      bad = 1'($urandom_range(1, 0));
      rand_words($urandom_range(40, 1), 0, wr);
      build(wr, bad, s_tmp);
      pulse_start();
      do_load("rand", s_tmp, wr, !bad, 2);
    end

    rand_words(1024, 16'h8000, wr);
    build(wr, 1'b0, s_tmp);
    pulse_start();
    do_load("full", s_tmp, wr, 1'b1, 0);
    check("full_last_addr", 32'(wr_q[wr_q.size()-1][25:16]), 32'h3FF);
    check("full_mem_last",  32'(mem[1023]), 32'(wr[1023]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
